vend_request_arbiter: RTL
=========================

// Module: vend_request_arbiter
// PURPOSE
//  Front-end controller between board switches and vending_machine_fsm.
//  - Synchronises and debounces the five raw switches (2 coins, 3 product selects).
//  - Turns each debounced rising edge into a pending request.
//  - Issues requests to the FSM one at a time, as single-cycle pulses with a hold-off gap.
//  - Stretches the FSM's dispense/change pulses so they are visible on LEDs.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before a level change is accepted (>=1)
//  GAP_CYCLES       4        idle cycles forced after every issued pulse (>=1)
//  STRETCH_CYCLES   25000000 LED on-time after a dispense/change pulse (>=1)
// PORTS
//  clk           in   1  system clock; all state on rising edge
//  reset_n       in   1  asynchronous assert, active-low reset
//  sw_raw        in   5  raw switches: [0]=coin5 [1]=coin10 [2]=sel1 [3]=sel2 [4]=sel3
//  dispense_in   in   1  dispense pulse from vending_machine_fsm
//  change_in     in   1  change pulse from vending_machine_fsm
//  coin_5        out  1  1-cycle request pulse to FSM
//  coin_10       out  1  1-cycle request pulse to FSM
//  select_1      out  1  1-cycle request pulse to FSM
//  select_2      out  1  1-cycle request pulse to FSM
//  select_3      out  1  1-cycle request pulse to FSM
//  pending       out  5  outstanding request bits, same index map as sw_raw
//  dropped       out  1  sticky: an edge arrived while its pending bit was already set
//  led_dispense  out  1  stretched dispense indicator
//  led_change    out  1  stretched change indicator
// BEHAVIOUR
//  Reset:
//  - Every output, synchroniser flop, debounced level, counter and pending bit is 0; FSM state = IDLE.
//  - Assertion mid-pulse or mid-stretch drops the output immediately (async).
//  Synchroniser: 2 flops per switch; sw_raw is never used unsynchronised.
//  Debounce (per switch):
//  - Counter increments while sync level != debounced level; clears when they are equal.
//  - At count == DEBOUNCE_CYCLES-1 the debounced level takes the sync level and the counter clears.
//  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
//  Request capture:
//  - Debounced 0->1 sets pending[i]. Falling edges are ignored.
//  - Edge while pending[i]=1: request is lost and dropped is set (sticky until reset).
//  - Edge in the same cycle as issue-clear of bit i: bit stays set and dropped is not set (set wins).
//  Arbiter FSM (IDLE, ISSUE, GAP):
//  - IDLE -> ISSUE when pending != 0. The winner is latched by fixed priority:
//    coin10 > coin5 > sel1 > sel2 > sel3, so credit lands before selection.
//  - ISSUE (exactly 1 cycle): the winner's output pulse is high and its pending bit clears -> GAP.
//  - GAP: GAP_CYCLES cycles with all pulses low -> IDLE.
//  - At most one request pulse is high in any cycle (one-hot or zero).
//  Latency, idle arbiter, clean switch:
//  - Raw rise sampled at edge 0 -> pulse high during cycle DEBOUNCE_CYCLES+4.
//  - Breakdown: 2 sync + DEBOUNCE_CYCLES + 1 capture + 1 issue.
//  - Back-to-back pulses are spaced GAP_CYCLES+1... exactly 1+GAP_CYCLES cycles apart (start to start).
//  LED stretch:
//  - dispense_in/change_in high -> counter loads STRETCH_CYCLES; LED high while counter != 0.
//  - A new pulse during stretch reloads the counter (retrigger); no underflow at 0.
//  Widths:
//  - Counters are $clog2(param+1) bits; they saturate and never wrap.
// STRUCTURE
//  - Package vend_pkg: sw index constants (IDX_COIN5..IDX_SEL3), NUM_REQ=5, arbiter state enum, priority order.
//  - Sub-module vend_debounce (sync + debounce + rise detect, one switch), instantiated NUM_REQ times.
//  - Arbiter, pending register and both LED stretchers live in this module.
// TESTING (bench: DEBOUNCE_CYCLES=3, GAP_CYCLES=2, STRETCH_CYCLES=5)
//  - Reset/latency: hold reset_n=0, all outputs 0; release, raise sw_raw[1] ->
//    coin_10 high 1 cycle at cycle 7; pending=00000 afterwards.
//  - Bounce: toggle sw_raw[0] every 2 cycles for 10 cycles, then hold 1 ->
//    exactly one coin_5 pulse; no pulse during bouncing.
//  - Simultaneous: sw_raw 00000->11111 in one cycle -> pulses coin_10, coin_5, select_1, select_2, select_3
//    in that order, 3 cycles apart; never two high together.
//  - Drop: sel1 edge, release, second sel1 edge, both before issue (block with a pending coin10) ->
//    one select_1 pulse, dropped=1.
//  - Stretch: dispense_in pulse -> led_dispense high 5 cycles; second pulse at cycle 3 -> high through cycle 8.
//  - Reset mid-op: reset_n=0 during ISSUE -> pulse and LEDs fall without a clock edge;
//    after release pending=0, no stale pulse.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants for the vending front end: switch index map, arbiter states
// and the fixed request priority (credit before selection).
package vend_pkg;

    localparam int NUM_REQ    = 5;
    localparam int IDX_COIN5  = 0;
    localparam int IDX_COIN10 = 1;
    localparam int IDX_SEL1   = 2;
    localparam int IDX_SEL2   = 3;
    localparam int IDX_SEL3   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Highest priority first.
    localparam int PRIO_ORDER [NUM_REQ] = '{IDX_COIN10, IDX_COIN5, IDX_SEL1, IDX_SEL2, IDX_SEL3};

    function automatic logic [NUM_REQ-1:0] pick_grant(input logic [NUM_REQ-1:0] req);
        logic [NUM_REQ-1:0] grant;
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[PRIO_ORDER[i]]) begin
                grant                = '0;
                grant[PRIO_ORDER[i]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/vend_debounce.sv
// One switch: two-flop synchroniser, stable-count debounce and a registered
// single-cycle pulse on every accepted 0->1 transition.
module vend_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sw_raw,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // NOTE: non-blocking (<=) on every flop so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_sw_raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/vend_request_arbiter.sv
// Switch front end for vending_machine_fsm: debounced edges become pending
// requests, issued one pulse at a time with a hold-off gap; LED pulse stretchers.
module vend_request_arbiter
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GAP_CYCLES      = 4,
    parameter int STRETCH_CYCLES  = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] sw_raw,
    input  logic       dispense_in,
    input  logic       change_in,
    output logic       coin_5,
    output logic       coin_10,
    output logic       select_1,
    output logic       select_2,
    output logic       select_3,
    output logic [4:0] pending,
    output logic       dropped,
    output logic       led_dispense,
    output logic       led_change
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    logic [NUM_REQ-1:0] w_rise;
    logic [NUM_REQ-1:0] w_clear;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_dropped;
    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               w_load;
    logic [GW-1:0]      r_gap_cnt;
    logic [SW-1:0]      r_disp_cnt;
    logic [SW-1:0]      r_chg_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_db
        vend_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .i_sw_raw(sw_raw[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_clear = (r_state == ST_ISSUE) ? r_grant : '0;

    // A new edge in the same cycle as the issue-clear re-arms the bit instead of dropping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
            if (|(w_rise & r_pending & ~w_clear)) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = ST_ISSUE;
                    w_load      = 1'b1;
                end
            end
            ST_ISSUE: w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    if (|r_pending) begin
                        w_state_nxt = ST_ISSUE;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_grant <= pick_grant(r_pending);
            end
            if (r_state == ST_GAP && w_state_nxt == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_cnt <= '0;
            r_chg_cnt  <= '0;
        end else begin
            if (dispense_in) begin
                r_disp_cnt <= SW'(STRETCH_CYCLES);
            end else if (r_disp_cnt != '0) begin
                r_disp_cnt <= r_disp_cnt - 1'b1;
            end
            if (change_in) begin
                r_chg_cnt <= SW'(STRETCH_CYCLES);
            end else if (r_chg_cnt != '0) begin
                r_chg_cnt <= r_chg_cnt - 1'b1;
            end
        end
    end

    // Outputs decode straight from flops so an asserted reset drops them without a clock.
    assign {select_3, select_2, select_1, coin_10, coin_5} = w_clear;
    assign pending      = r_pending;
    assign dropped      = r_dropped;
    assign led_dispense = (r_disp_cnt != '0);
    assign led_change   = (r_chg_cnt != '0);

endmodule
